// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Constants shared by the MIPS datapath blocks: register file, ALU, decoder
//   and pipeline registers. Holds the datapath widths, the architectural
//   register indices that get special treatment, and the stack pointer's
//   reset value.
//
//   Contents:
//     DATA_W           - register and data width in bits
//     ADDR_W           - register index width (2**ADDR_W registers)
//     NUM_REGS         - number of architectural registers
//     REG_ZERO/AT/SP/RA- architectural register indices
//     SP_RESET_DEFAULT - value loaded into $sp on reset
//     reg_reset_value  - reset value of a given register index
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   // Architectural register indices with special meaning.
   localparam int REG_ZERO = 0;
   localparam int REG_AT   = 1;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

   // Top of the initial stack: last word-aligned address of a 16 KiB region.
   localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_3FFC;

   // Reset value of register 'idx': $sp starts at 'sp_value', all others at 0.
   function automatic logic [31:0] reg_reset_value(input int idx,
                                                   input logic [31:0] sp_value);
      logic [31:0] value;
      value = 32'h0000_0000;
      if (idx == REG_SP) begin
         value = sp_value;
      end else begin
         value = 32'h0000_0000;
      end
      return value;
   endfunction

endpackage : mips_pkg

// File: rtl/reg_read_port.sv
// -----------------------------------------------------------------------------
// reg_read_port
//   One combinational read port of the register file. Selects between the
//   hardwired zero register, the value being written back in this same cycle
//   (bypass), and the stored array word.
//
//   Ports:
//     index      in  [ADDR_W-1:0]  register index requested by this port
//     array_word in  [DATA_W-1:0]  stored array word at 'index'
//     write_reg  in  [ADDR_W-1:0]  destination index of the current writeback
//     write_data in  [DATA_W-1:0]  value of the current writeback
//     reg_write  in  1             writeback enable
//     reset      in  1             active-high reset; suppresses the bypass
//     read_data  out [DATA_W-1:0]  operand delivered to the ALU
// -----------------------------------------------------------------------------
module reg_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic [ADDR_W-1:0] index,
   input  logic [DATA_W-1:0] array_word,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   input  logic              reset,
   output logic [DATA_W-1:0] read_data
);

   logic is_zero_s;
   logic bypass_hit_s;

   // Decode the zero index and the same-cycle bypass condition.
   always_comb begin
      is_zero_s    = 1'b0;
      bypass_hit_s = 1'b0;
      if (index == ADDR_W'(REG_ZERO)) begin
         is_zero_s = 1'b1;
      end else begin
         is_zero_s = 1'b0;
      end
      // A write to $zero never bypasses, and nothing bypasses during reset
      // because the array is being held at its reset values.
      if (reg_write && !reset &&
          (write_reg == index) &&
          (write_reg != ADDR_W'(REG_ZERO))) begin
         bypass_hit_s = 1'b1;
      end else begin
         bypass_hit_s = 1'b0;
      end
   end

   // Priority mux: zero register, then bypass, then stored word.
   always_comb begin
      read_data = '0;
      if (is_zero_s) begin
         read_data = '0;
      end else if (bypass_hit_s) begin
         read_data = write_data;
      end else begin
         read_data = array_word;
      end
   end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   32 x 32-bit MIPS general-purpose register file feeding the ALU operands.
//   Two combinational read ports with same-cycle write bypass, one synchronous
//   write port. $zero is hardwired to 0 and never stored; $sp resets to
//   SP_RESET, every other register resets to 0.
//
//   Ports:
//     clk        in  1             system clock, rising-edge active
//     reset      in  1             asynchronous active-high reset
//     read_reg1  in  [ADDR_W-1:0]  rs index (operand A)
//     read_reg2  in  [ADDR_W-1:0]  rt index (operand B)
//     write_reg  in  [ADDR_W-1:0]  writeback destination index
//     write_data in  [DATA_W-1:0]  writeback value
//     reg_write  in  1             writeback enable
//     read_data1 out [DATA_W-1:0]  operand A to the ALU
//     read_data2 out [DATA_W-1:0]  operand B to the ALU
// -----------------------------------------------------------------------------
module reg_file
   import mips_pkg::*;
#(
   parameter int                      DATA_W   = mips_pkg::DATA_W,
   parameter int                      ADDR_W   = mips_pkg::ADDR_W,
   parameter logic [DATA_W-1:0]       SP_RESET = DATA_W'(mips_pkg::SP_RESET_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   localparam int NREGS = 2 ** ADDR_W;

   // Flattened view of the register array; entry 0 is a constant, not a flop.
   logic [DATA_W-1:0] regs_s [NREGS];
   logic              wr_en_s;
   logic [DATA_W-1:0] word1_s;
   logic [DATA_W-1:0] word2_s;

   // Qualify the write: writes targeting $zero are dropped.
   always_comb begin
      wr_en_s = 1'b0;
      if (reg_write && (write_reg != ADDR_W'(REG_ZERO))) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_reg
      if (g == REG_ZERO) begin : g_zero
         assign regs_s[g] = '0;
      end else begin : g_store
         // $sp resets to SP_RESET, every other register to 0.
         localparam logic [DATA_W-1:0] RST_VAL =
            (g == REG_SP) ? SP_RESET : {DATA_W{1'b0}};

         logic [DATA_W-1:0] q_r;

         // Storage flop for this register; reset takes precedence over writes.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               q_r <= RST_VAL;
            end else if (wr_en_s && (write_reg == ADDR_W'(g))) begin
               q_r <= write_data;
            end else begin
               q_r <= q_r;
            end
         end

         assign regs_s[g] = q_r;
      end
   end

   // Fetch the stored word for each read index.
   always_comb begin
      word1_s = regs_s[read_reg1];
      word2_s = regs_s[read_reg2];
   end

   reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_port1 (
      .index      (read_reg1),
      .array_word (word1_s),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .reset      (reset),
      .read_data  (read_data1)
   );

   reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_port2 (
      .index      (read_reg2),
      .array_word (word2_s),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .reset      (reset),
      .read_data  (read_data2)
   );

endmodule : reg_file
